// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back end of the five-stage pipeline
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   *_E, flush_E          instruction leaving execute and its kill request
//   dm_req/we/addr/wdata  data-memory request; dm_ack/dm_rdata response
//   stall_M               hold PC, IF/ID and ID/EX while an access is pending
//   dm_err                sticky access-timeout flag
//   EX_MEM_*, MEM_WB_*    forwarding bus for the execute-stage forwarding unit
//   regWrite_W, writeAddr_W, writeData_W  register-file write port
module mem_wb_stage #(
   parameter int N       = 64,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic         regWrite_E,
   input  logic         memRead_E,
   input  logic         memWrite_E,
   input  logic         memtoReg_E,
   input  logic [4:0]   rd_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic         flush_E,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic         stall_M,
   output logic         dm_err,
   output logic [4:0]   EX_MEM_rd,
   output logic         EX_MEM_regWrite,
   output logic [N-1:0] EX_MEM_aluResult,
   output logic [4:0]   MEM_WB_rd,
   output logic         MEM_WB_regWrite,
   output logic [N-1:0] MEM_WB_aluResult,
   output logic         regWrite_W,
   output logic [4:0]   writeAddr_W,
   output logic [N-1:0] writeData_W
);
   typedef enum logic {ACCESS, DRAIN} state_t;
   state_t       state, state_nx;
   logic [7:0]   cnt, cnt_nx;
   logic         err_nx;
   logic         valid_m, reg_write_m, mem_read_m, mem_write_m, memto_reg_m;
   logic [4:0]   rd_m;
   logic [N-1:0] alu_m, wdata_m;
   logic         valid_w, reg_write_w;
   logic [4:0]   rd_w;
   logic [N-1:0] wb_w;
   logic         memop_m, ack_now;
   logic [N-1:0] load_data, wb_nx;
   assign memop_m   = valid_m & (mem_read_m | mem_write_m);
   assign dm_req    = memop_m & (state == ACCESS);
   assign dm_we     = mem_write_m;
   assign dm_addr   = alu_m;
   assign dm_wdata  = wdata_m;
   assign ack_now   = dm_req & dm_ack;
   // state is only ACCESS or DRAIN, so this equals memop & ~(ACCESS & ack) & ~DRAIN
   assign stall_M   = dm_req & ~dm_ack;
   // a drained (timed-out) load writes back zero instead of stale bus data
   assign load_data = ack_now ? dm_rdata : '0;
   assign wb_nx     = memto_reg_m ? load_data : alu_m;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      err_nx   = dm_err;
      if (state == DRAIN) begin
         state_nx = ACCESS;
         cnt_nx   = '0;
      end else if (ack_now) begin
         cnt_nx = '0;
      end else if (dm_req) begin
         if (cnt == 8'(TIMEOUT - 1)) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
            err_nx   = 1'b1;
         end else begin
            cnt_nx = cnt + 8'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ACCESS;
         cnt    <= '0;
         dm_err <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         dm_err <= err_nx;
      end
   end
   // M register: holds while stalled, so flush_E cannot kill a pending access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_m     <= 1'b0;
         reg_write_m <= 1'b0;
         mem_read_m  <= 1'b0;
         mem_write_m <= 1'b0;
         memto_reg_m <= 1'b0;
         rd_m        <= '0;
         alu_m       <= '0;
         wdata_m     <= '0;
      end else if (!stall_M) begin
         if (valid_E && !flush_E) begin
            valid_m     <= 1'b1;
            reg_write_m <= regWrite_E;
            mem_read_m  <= memRead_E;
            mem_write_m <= memWrite_E;
            memto_reg_m <= memtoReg_E;
            rd_m        <= rd_E;
            alu_m       <= aluResult_E;
            wdata_m     <= writeData_E;
         end else begin
            valid_m     <= 1'b0;
            reg_write_m <= 1'b0;
            mem_read_m  <= 1'b0;
            mem_write_m <= 1'b0;
            memto_reg_m <= 1'b0;
            rd_m        <= '0;
            alu_m       <= '0;
            wdata_m     <= '0;
         end
      end
   end
   // W register: a bubble while stalled so a waiting instruction is written once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_w     <= 1'b0;
         reg_write_w <= 1'b0;
         rd_w        <= '0;
         wb_w        <= '0;
      end else if (stall_M) begin
         valid_w     <= 1'b0;
         reg_write_w <= 1'b0;
         rd_w        <= '0;
         wb_w        <= '0;
      end else begin
         valid_w     <= valid_m;
         reg_write_w <= reg_write_m;
         rd_w        <= rd_m;
         wb_w        <= wb_nx;
      end
   end
   // a load's address is not its result; load-use is the hazard unit's job
   assign EX_MEM_rd        = rd_m;
   assign EX_MEM_regWrite  = valid_m & reg_write_m & ~memto_reg_m & (rd_m != 5'd31);
   assign EX_MEM_aluResult = alu_m;
   assign regWrite_W       = valid_w & reg_write_w & (rd_w != 5'd31);
   assign writeAddr_W      = rd_w;
   assign writeData_W      = wb_w;
   assign MEM_WB_rd        = rd_w;
   assign MEM_WB_regWrite  = regWrite_W;
   assign MEM_WB_aluResult = wb_w;
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back end of the five-stage pipeline.
- Captures the instruction leaving execute and performs its data-memory access over a req/ack handshake, stalling the front of the pipeline while the access is outstanding.
- Produces the register-file write port.
- Drives the EX/MEM and MEM/WB forwarding bus that the execute stage's forwarding unit consumes: rd, regWrite and result for each stage.

## Interface
Parameters
- N, 64, datapath width
- TIMEOUT, 15, maximum wait cycles for dm_ack before an access is abandoned (1..255)

Ports
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- valid_E  in  1  execute stage holds a real instruction
- regWrite_E, memRead_E, memWrite_E, memtoReg_E  in  1 each  control bits of that instruction
- rd_E  in  5  destination register
- aluResult_E  in  N  ALU result, also the memory address
- writeData_E  in  N  store data
- flush_E  in  1  kill the instruction in execute (taken branch)
- dm_req  out  1  memory request
- dm_we  out  1  1 = store, 0 = load
- dm_addr  out  N  memory address
- dm_wdata  out  N  store data
- dm_ack  in  1  memory completion
- dm_rdata  in  N  load data, valid when dm_ack=1
- stall_M  out  1  hold PC, IF/ID and ID/EX this cycle
- dm_err  out  1  sticky: an access timed out
- EX_MEM_rd  out  5  forwarding bus: M-stage destination
- EX_MEM_regWrite  out  1  forwarding bus: M-stage result is forwardable
- EX_MEM_aluResult  out  N  forwarding bus: M-stage result
- MEM_WB_rd  out  5  forwarding bus: W-stage destination
- MEM_WB_regWrite  out  1  forwarding bus: W-stage write enable
- MEM_WB_aluResult  out  N  forwarding bus: W-stage final write-back value
- regWrite_W  out  1  register-file write enable
- writeAddr_W  out  5  register-file write address
- writeData_W  out  N  register-file write data

## Operation
- M register: valid, control bits, rd, aluResult, writeData.
  - Loads from execute when stall_M=0.
  - Loads a bubble (valid=0) when flush_E=1 or valid_E=0.
  - Holds its value when stall_M=1.
  - flush_E is ignored while stall_M=1.
- memop_M = valid_M & (memRead_M | memWrite_M).
  - Priority: if both memRead_M and memWrite_M are set, the access is a store.
- dm_req = memop_M & (state==ACCESS).
  - dm_addr = aluResult_M, dm_wdata = writeData_M, dm_we = memWrite_M.
  - All four are stable while dm_req=1.
- FSM states: ACCESS, DRAIN.
  - ACCESS: the wait counter increments each cycle with dm_req=1 & dm_ack=0.
  - dm_ack=1 completes the access: M advances to W, counter clears, state stays ACCESS.
  - Counter reaching TIMEOUT with no ack goes to DRAIN and sets dm_err.
  - DRAIN (one cycle): the M instruction advances with load data forced to 0, dm_req=0, then back to ACCESS.
- stall_M = memop_M & ~(state==ACCESS & dm_ack) & ~(state==DRAIN).
- W register: loads from M when M advances.
  - Loads a bubble when stall_M=1, so nothing is written twice.
  - wbData = memtoReg ? load data : aluResult.
- XZR: rd==31 forces every regWrite derived from that instruction to 0.
- EX_MEM_regWrite = valid_M & regWrite_M & ~memtoReg_M & (rd_M!=31).
  - A load's address is never forwarded as data; load-use is handled by the hazard unit.
- EX_MEM_aluResult = aluResult_M.
- MEM_WB_regWrite = regWrite_W = valid_W & regWrite_W-bit & (rd_W!=31).
- MEM_WB_aluResult = writeData_W = wbData_W.
- EX_MEM_rd = rd_M; MEM_WB_rd = writeAddr_W = rd_W.
- dm_err is cleared only by reset.

## Timing
- Reset (reset low, asynchronous):
  - M and W valid = 0, all data and rd registers = 0, state = ACCESS, counter = 0, dm_err = 0.
  - Hence all outputs are 0, including stall_M and dm_req.
- Non-memory instruction: enters M at edge k, W at edge k+1, register-file write at edge k+2.
- Zero-wait access (dm_ack in the same cycle as dm_req): no stall, same latency as a non-memory instruction.
- An access acked after w wait cycles:
  - stall_M=1 for exactly w cycles.
  - W receives w bubbles, then the instruction.
- Timeout: stall_M=1 for TIMEOUT cycles, then one DRAIN cycle with stall_M=0.
- stall_M and dm_req are combinational from registered state and dm_ack; no combinational path from execute-stage inputs to stall_M.

## Test plan
- ADD X3 (rd=3, aluResult=0x10) then NOP:
  - EX_MEM_rd=3 and EX_MEM_regWrite=1 one cycle after capture.
  - Next cycle MEM_WB_aluResult=0x10 and regWrite_W=1.
  - stall_M stays 0 throughout.
- LDUR X5 at addr 0x40, dm_ack held off 3 cycles, dm_rdata=0xDEAD:
  - stall_M=1 for 3 cycles, EX_MEM_regWrite=0 throughout.
  - Then writeData_W=0xDEAD, writeAddr_W=5, exactly one write.
- STUR with dm_ack in the same cycle:
  - dm_we=1, dm_addr and dm_wdata correct, no stall.
  - regWrite_W=0.
- Instruction with rd=31, regWrite=1: EX_MEM_regWrite=0 and regWrite_W=0.
- flush_E=1 on a valid ADD: M becomes a bubble and no write occurs.
  - flush_E=1 during a load stall is ignored; the load still completes.
- Load with dm_ack never asserted, TIMEOUT=15:
  - 15 stall cycles, then dm_err=1 and the write-back value is 0.
  - Assert reset mid-stall: every output is 0 immediately, without waiting for a clock edge.
